servo_cmd_sequencer: RTL

Position-command stage feeding the servo PWM generator. Debounces two push-buttons, selects a target pulse width (left / neutral / right) and slews the commanded width toward it by a fixed step once per PWM frame. The output word changes only on the frame boundary reported by the PWM stage, so a pulse is never truncated or stretched mid-frame. All widths are in `clk` ticks, on the same count scale as the PWM counter.

---
 rtl/servo_cmd_sequencer.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/servo_cmd_sequencer.sv
// servo_cmd_sequencer: debounces the left/right buttons, picks a target pulse
// width and slews the commanded width toward it by at most STEP per PWM frame.
// pw_value only moves on a frame_tick so the PWM stage never sees a mid-frame
// change.
module servo_cmd_sequencer #(
    parameter int unsigned PW_MIN         = 11200,
    parameter int unsigned PW_MID         = 40350,
    parameter int unsigned PW_MAX         = 69500,
    parameter int unsigned STEP           = 1458,
    parameter int unsigned DEBOUNCE_TICKS = 270000,
    parameter int unsigned W              = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         btn_left_n,
    input  logic         btn_right_n,
    input  logic         frame_tick,
    output logic [W-1:0] pw_value,
    output logic         pw_update,
    output logic         busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_TICKS + 1);

    localparam logic [W-1:0]     MIN_V    = W'(PW_MIN);
    localparam logic [W-1:0]     MID_V    = W'(PW_MID);
    localparam logic [W-1:0]     MAX_V    = W'(PW_MAX);
    localparam logic [W-1:0]     STEP_V   = W'(STEP);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

    typedef enum logic [1:0] {
        SETTLED   = 2'd0,
        SLEW_UP   = 2'd1,
        SLEW_DOWN = 2'd2
    } state_t;

    // Index 0 is the left button, index 1 the right button.
    logic [1:0]       raw;
    logic [1:0]       sync1_q;
    logic [1:0]       sync2_q;
    logic [1:0]       deb_q;
    logic [1:0]       press_q;
    logic [CNT_W-1:0] cnt_q [2];

    logic [W-1:0] target_q;
    logic [W-1:0] target_d;
    logic [W-1:0] pos_q;
    logic [W-1:0] pos_d;
    state_t       state_q;
    state_t       state_d;
    logic         upd_q;
    logic         busy_q;

    assign raw = {btn_right_n, btn_left_n};

    // Move up by STEP but never past the target. pos < tgt is known here and
    // PW_MAX+STEP fits in W bits, so the sum cannot wrap.
    function automatic logic [W-1:0] step_up(input logic [W-1:0] pos,
                                             input logic [W-1:0] tgt);
        logic [W-1:0] sum;
        sum = pos + STEP_V;
        return (sum > tgt) ? tgt : sum;
    endfunction

    // Move down by STEP but never below the target. pos > tgt >= PW_MIN >= STEP,
    // so the difference cannot wrap.
    function automatic logic [W-1:0] step_down(input logic [W-1:0] pos,
                                               input logic [W-1:0] tgt);
        logic [W-1:0] diff;
        diff = pos - STEP_V;
        return (diff < tgt) ? tgt : diff;
    endfunction

    // Two-flop synchronisers; idle level is released (1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // Debouncers: accept a new level after DEBOUNCE_TICKS consecutive
    // mismatching cycles and flag a one-cycle press on a 1->0 acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q   <= 2'b11;
            press_q <= 2'b00;
            for (int b = 0; b < 2; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < 2; b++) begin
                press_q[b] <= 1'b0;
                if (sync2_q[b] != deb_q[b]) begin
                    if (cnt_q[b] == CNT_LAST) begin
                        deb_q[b]   <= sync2_q[b];
                        press_q[b] <= deb_q[b] & ~sync2_q[b];
                        cnt_q[b]   <= '0;
                    end else begin
                        cnt_q[b] <= cnt_q[b] + 1'b1;
                    end
                end else begin
                    cnt_q[b] <= '0;
                end
            end
        end
    end

    // Target selection from press events only; a held button does not matter.
    always_comb begin
        target_d = target_q;
        unique case (press_q)
            2'b01:   target_d = MIN_V;
            2'b10:   target_d = MAX_V;
            2'b11:   target_d = MID_V;
            default: target_d = target_q;
        endcase
    end

    // Target register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            target_q <= MID_V;
        end else begin
            target_q <= target_d;
        end
    end

    // Next slew direction and next commanded width. The guards on the current
    // target keep a target change that lands one cycle before a tick from
    // pulling pos the wrong way; that frame simply holds.
    always_comb begin
        state_d = SETTLED;
        if (pos_q < target_q) begin
            state_d = SLEW_UP;
        end else if (pos_q > target_q) begin
            state_d = SLEW_DOWN;
        end

        pos_d = pos_q;
        if (frame_tick) begin
            unique case (state_q)
                SLEW_UP: begin
                    if (pos_q < target_q) begin
                        pos_d = step_up(pos_q, target_q);
                    end
                end
                SLEW_DOWN: begin
                    if (pos_q > target_q) begin
                        pos_d = step_down(pos_q, target_q);
                    end
                end
                default: pos_d = pos_q;
            endcase
        end
    end

    // Slew FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SETTLED;
            pos_q   <= MID_V;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            upd_q   <= frame_tick;
            busy_q  <= (state_d != SETTLED);
        end
    end

    assign pw_value  = pos_q;
    assign pw_update = upd_q;
    assign busy      = busy_q;

endmodule
